mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified single-port memory between the core's instruction-fetch master (imem_*) and data/LSU master (dmem_*).
//  Sits between the core's imem/dmem interfaces and the memory. Grants one master at a time and registers the winning request.
//  Returns ready/rdata only to the granted master. Adds a response timeout that flags errors.
// PARAMETERS
//  ADDR_WIDTH      32  address width of both masters and the memory port
//  DATA_WIDTH      32  data width; byte-enable width is DATA_WIDTH/8
//  TIMEOUT_CYCLES  64  max cycles in a grant state before forced completion; 0 = timeout disabled
// PORTS
//  clk           in   1    clock
//  rst_n         in   1    asynchronous reset, active low
//  imem_valid_i  in   1    fetch request; held until imem_ready_o
//  imem_ready_o  out  1    1-cycle pulse: fetch request complete
//  imem_addr_i   in   AW   fetch address
//  imem_rdata_o  out  DW   fetch read data; valid with imem_ready_o
//  dmem_valid_i  in   1    data request; held until dmem_ready_o
//  dmem_ready_o  out  1    1-cycle pulse: data request complete
//  dmem_addr_i   in   AW   data address
//  dmem_wdata_i  in   DW   data write data
//  dmem_we_i     in   DW/8 byte write enables; 0 = read
//  dmem_rdata_o  out  DW   data read data; valid with dmem_ready_o
//  mem_valid_o   out  1    request to memory
//  mem_ready_i   in   1    memory completion pulse
//  mem_addr_o    out  AW   latched address
//  mem_wdata_o   out  DW   latched write data (0 for fetch)
//  mem_we_o      out  DW/8 latched byte enables (0 for fetch)
//  mem_rdata_i   in   DW   memory read data
//  err_o         out  1    1-cycle pulse with the ready pulse when completion was forced by timeout
// BEHAVIOUR
//  States: IDLE, GNT_I, GNT_D. Reset (async) -> IDLE. All outputs 0; timeout counter 0; round-robin pointer -> dmem.
//  IDLE
//   - No request: stay in IDLE.
//   - Both valid: dmem wins (fixed priority).
//   - Winner's addr/wdata/we latched at the clock edge; state -> GNT_x.
//   - Fetch always latches wdata=0 and we=0.
//  GNT_x
//   - mem_valid_o=1; mem_* driven from the latched registers only.
//   - Requester input changes or valid drops are ignored until completion.
//   - Completion on mem_ready_i=1: same cycle, x_ready_o=1 and x_rdata_o=mem_rdata_i (combinational pass-through). Next state IDLE.
//   - Non-granted master: ready_o=0, rdata_o=0 at all times.
//   - Latency: request seen in IDLE at cycle N; mem_valid_o at N+1; earliest ready at N+1.
//   - One IDLE bubble cycle between back-to-back grants.
//  Timeout (TIMEOUT_CYCLES>0)
//   - Counter clears on grant entry and increments each GNT cycle without mem_ready_i.
//   - At count==TIMEOUT_CYCLES-1 with no ready: x_ready_o=1, x_rdata_o=0, err_o=1; next state IDLE.
//   - mem_ready_i in IDLE is ignored (late responses dropped).
//   - mem_ready_i in the same cycle as the timeout: normal completion wins; err_o=0.
//  General
//   - mem_ready_i is sampled only in GNT states.
//   - Counter width: $clog2(TIMEOUT_CYCLES+1); saturates and never wraps.
//   - Reset mid-grant: immediately IDLE, mem_valid_o=0; the in-flight access is abandoned and no ready is issued.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined
//   - When both valid in IDLE, the master not served last wins.
//   - Pointer updates on each completion, including timeout.
//   - Reset pointer favours dmem first.
//  MEM_ARB_ROUND_ROBIN_EN undefined
//   - Fixed priority: dmem > imem; no pointer register.
// TESTING
//  1. Fetch only: imem_valid_i=1, addr=0x100; mem_ready_i after 2 cycles with rdata=0xDEADBEEF.
//     -> mem_addr_o=0x100, mem_we_o=0; imem_ready_o pulse with 0xDEADBEEF; err_o=0.
//  2. Simultaneous: imem addr 0x0, dmem write addr 0x2000, we=0xF, wdata=0x12345678.
//     -> dmem granted first (mem_we_o=0xF); after its ready, IDLE bubble, then imem granted.
//  3. With MEM_ARB_ROUND_ROBIN_EN: both held valid for 4 transactions.
//     -> grant order D,I,D,I; without macro -> D,D,D,D (imem starved while dmem is valid).
//  4. TIMEOUT_CYCLES=4, mem_ready_i held 0.
//     -> after 4 GNT cycles: dmem_ready_o=1, err_o=1, rdata=0; a late mem_ready_i in IDLE is ignored.
//  5. Assert rst_n=0 mid-GNT_D.
//     -> mem_valid_o=0 asynchronously; no ready pulse; after release, a pending imem request is granted normally.
//  6. Granted master changes addr 0x40->0x80 mid-grant.
//     -> mem_addr_o stays 0x40 until completion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/LSU arbiter for one shared single-port memory.
// MEM_ARB_ROUND_ROBIN_EN: round-robin instead of dmem-first priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_valid_i,
  output logic                    imem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  input  logic                    dmem_valid_i,
  output logic                    dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0]         we_q;
  logic [CW-1:0]         cnt_q;
  logic                  any_req;
  logic                  pick_d;
  logic                  tmo;
  logic                  done;

  assign any_req = imem_valid_i | dmem_valid_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q;

  assign pick_d = dmem_valid_i & (~imem_valid_i | rr_q);

  // Favour the master that was not served by the last completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b1;
    end else if (done) begin
      rr_q <= (state_q == GNT_I);
    end
  end
`else
  assign pick_d = dmem_valid_i;
`endif

  assign tmo = (TIMEOUT_CYCLES > 0) &&
               (cnt_q == CNT_LAST) && !mem_ready_i;
  assign done = (state_q != IDLE) && (mem_ready_i || tmo);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant from IDLE, return to IDLE on completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = pick_d ? GNT_D : GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request; inputs are ignored while granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else if (state_q == IDLE && any_req) begin
      if (pick_d) begin
        addr_q  <= dmem_addr_i;
        wdata_q <= dmem_wdata_i;
        we_q    <= dmem_we_i;
      end else begin
        addr_q  <= imem_addr_i;
        wdata_q <= '0;
        we_q    <= '0;
      end
    end
  end

  // Grant-age counter, cleared in IDLE, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!mem_ready_i && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;

  // Route completion and read data to the granted master only.
  always_comb begin
    mem_valid_o  = (state_q != IDLE);
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    imem_rdata_o = '0;
    dmem_rdata_o = '0;
    err_o        = done & tmo;
    unique case (1'b1)
      (state_q == GNT_I): begin
        imem_ready_o = done;
        if (mem_ready_i) begin
          imem_rdata_o = mem_rdata_i;
        end
      end
      (state_q == GNT_D): begin
        dmem_ready_o = done;
        if (mem_ready_i) begin
          dmem_rdata_o = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Directed vectors; grants and responses checked by a monitor.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } gnt_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_valid;
  logic        dmem_ready;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  int lat = 2;
  bit mem_en = 1'b1;
  bit late = 1'b0;
  bit prev_v = 1'b0;

  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t cur;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_valid_i(imem_valid),
    .imem_ready_o(imem_ready),
    .imem_addr_i(imem_addr),
    .imem_rdata_o(imem_rdata),
    .dmem_valid_i(dmem_valid),
    .dmem_ready_o(dmem_ready),
    .dmem_addr_i(dmem_addr),
    .dmem_wdata_i(dmem_wdata),
    .dmem_we_i(dmem_we),
    .dmem_rdata_o(dmem_rdata),
    .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic [31:0] a,
                        input logic [31:0] w,
                        input logic [3:0] we);
    gnt_t g;
    g.addr = a;
    g.wdata = w;
    g.we = we;
    gq.push_back(g);
  endtask

  task automatic push_r(input logic d,
                        input logic [31:0] rd,
                        input logic e);
    rsp_t r;
    r.is_d = d;
    r.rdata = rd;
    r.err = e;
    rq.push_back(r);
  endtask

  // Memory model: ready after lat grant cycles, data from address.
  initial begin
    int cyc;
    cyc = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h1234_5678;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid) begin
        cyc++;
        mem_ready = mem_en && (cyc == lat);
        if (mem_ready) begin
          mem_rdata = (mem_addr == 32'h100) ? 32'hDEAD_BEEF
                                            : ~mem_addr;
        end else begin
          mem_rdata = 32'hCAFE_F00D;
        end
      end else begin
        cyc = 0;
        mem_ready = late;
        mem_rdata = 32'h1234_5678;
      end
    end
  end

  // Monitor: grants, held address, responses, idle outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid && !prev_v) begin
        if (gq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL grant: unexpected addr %h", mem_addr);
        end else begin
          cur = gq.pop_front();
          chk("gnt_wdata", mem_wdata, cur.wdata);
          chk("gnt_we", {28'd0, mem_we}, {28'd0, cur.we});
        end
      end
      if (mem_valid) chk("gnt_addr", mem_addr, cur.addr);
      if (!imem_ready) chk("imem_rdata_idle", imem_rdata, 32'd0);
      if (!dmem_ready) chk("dmem_rdata_idle", dmem_rdata, 32'd0);
      if (imem_ready || dmem_ready) begin
        if (rq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp: unexpected ready i=%b d=%b",
                   imem_ready, dmem_ready);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rsp_both", {31'd0, imem_ready & dmem_ready}, 32'd0);
          chk("rsp_who", {31'd0, dmem_ready}, {31'd0, r.is_d});
          chk("rsp_rdata", dmem_ready ? dmem_rdata : imem_rdata,
              r.rdata);
          chk("rsp_err", {31'd0, err}, {31'd0, r.err});
        end
      end else begin
        chk("err_idle", {31'd0, err}, 32'd0);
      end
      prev_v = mem_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic do_i(input logic [31:0] a);
    bit got;
    got = 1'b0;
    imem_valid = 1'b1;
    imem_addr = a;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (imem_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("imem_wait", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] a,
                      input logic [31:0] w,
                      input logic [3:0] we);
    bit got;
    got = 1'b0;
    dmem_valid = 1'b1;
    dmem_addr = a;
    dmem_wdata = w;
    dmem_we = we;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dmem_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("dmem_wait", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    dmem_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_wait", {31'd0, got}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid = 1'b0;
    imem_addr = '0;
    dmem_valid = 1'b0;
    dmem_addr = '0;
    dmem_wdata = '0;
    dmem_we = '0;
    #3;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_imem_ready", {31'd0, imem_ready}, 32'd0);
    chk("rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_we", {28'd0, mem_we}, 32'd0);
    apply_reset();

    // Fetch only.
    push_g(32'h100, 32'h0, 4'h0);
    push_r(1'b0, 32'hDEAD_BEEF, 1'b0);
    do_i(32'h100);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous: dmem write first, then fetch.
    push_g(32'h2000, 32'h1234_5678, 4'hF);
    push_r(1'b1, 32'hFFFF_DFFF, 1'b0);
    push_g(32'h0, 32'h0, 4'h0);
    push_r(1'b0, 32'hFFFF_FFFF, 1'b0);
    fork
      do_d(32'h2000, 32'h1234_5678, 4'hF);
      do_i(32'h0);
    join
    apply_reset();

    // Both held valid over several transactions.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_g(32'h3000, 0, 0); push_r(1'b1, 32'hFFFF_CFFF, 1'b0);
    push_g(32'h10, 0, 0);   push_r(1'b0, 32'hFFFF_FFEF, 1'b0);
    push_g(32'h3004, 0, 0); push_r(1'b1, 32'hFFFF_CFFB, 1'b0);
    push_g(32'h14, 0, 0);   push_r(1'b0, 32'hFFFF_FFEB, 1'b0);
    push_g(32'h3008, 0, 0); push_r(1'b1, 32'hFFFF_CFF7, 1'b0);
    push_g(32'h300C, 0, 0); push_r(1'b1, 32'hFFFF_CFF3, 1'b0);
`else
    push_g(32'h3000, 0, 0); push_r(1'b1, 32'hFFFF_CFFF, 1'b0);
    push_g(32'h3004, 0, 0); push_r(1'b1, 32'hFFFF_CFFB, 1'b0);
    push_g(32'h3008, 0, 0); push_r(1'b1, 32'hFFFF_CFF7, 1'b0);
    push_g(32'h300C, 0, 0); push_r(1'b1, 32'hFFFF_CFF3, 1'b0);
    push_g(32'h10, 0, 0);   push_r(1'b0, 32'hFFFF_FFEF, 1'b0);
    push_g(32'h14, 0, 0);   push_r(1'b0, 32'hFFFF_FFEB, 1'b0);
`endif
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          do_d(32'h3000 + 32'(j * 4), 32'h0, 4'h0);
        end
      end
      begin
        do_i(32'h10);
        do_i(32'h14);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Timeout with memory silent, then a late ready in IDLE.
    mem_en = 1'b0;
    push_g(32'h44, 32'h0, 4'h0);
    push_r(1'b1, 32'h0, 1'b1);
    do_d(32'h44, 32'h0, 4'h0);
    @(negedge clk);
    late = 1'b1;
    @(negedge clk);
    chk("late_mem_ready_seen", {31'd0, mem_ready}, 32'd1);
    chk("late_dmem_ready", {31'd0, dmem_ready}, 32'd0);
    chk("late_err", {31'd0, err}, 32'd0);
    chk("late_valid", {31'd0, mem_valid}, 32'd0);
    late = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_after_valid", {31'd0, mem_valid}, 32'd0);
    mem_en = 1'b1;

    // Reset mid-grant, pending fetch served afterwards.
    lat = 3;
    push_g(32'h500, 32'hAAAA_5555, 4'h3);
    @(posedge clk);
    #1;
    dmem_valid = 1'b1;
    dmem_addr = 32'h500;
    dmem_wdata = 32'hAAAA_5555;
    dmem_we = 4'h3;
    wait_grant();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, dmem_ready}, 32'd0);
    dmem_valid = 1'b0;
    imem_valid = 1'b1;
    imem_addr = 32'h600;
    push_g(32'h600, 32'h0, 4'h0);
    push_r(1'b0, 32'hFFFF_F9FF, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_i(32'h600);
    repeat (2) @(posedge clk);
    #1;

    // Address change mid-grant must not reach the memory.
    push_g(32'h40, 32'h0, 4'h0);
    push_r(1'b1, 32'hFFFF_FFBF, 1'b0);
    fork
      do_d(32'h40, 32'h0, 4'h0);
      begin
        wait_grant();
        dmem_addr = 32'h80;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("gq_empty", gq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
